btn_debounce_multi: RTL and testbench

Parametrised multi-channel push-button conditioner: one instance replaces per-button debouncers on the board test layer.
Each channel has a 2-flop synchroniser and a consecutive-stable-count debouncer, and gives a clean level plus one-cycle rise/fall strobes.
An optional per-channel auto-repeat produces press strobes while a button is held, for stepping the CPU clock or scrolling display mux selects.
Sits between board button pins and the manual-clock / display-select logic, all in the 100 MHz domain.

---
 rtl/btn_debounce_multi.sv | 140 ++++++++++++++
 tb/tb_btn_debounce_multi.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// Multi-channel push-button conditioner: 2-flop synchroniser, stable-count debouncer,
// registered rise/fall strobes and an optional per-channel auto-repeat press generator.
module btn_debounce_multi #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 21,
  parameter int STABLE_CYCLES = 2000000,
  parameter int RPT_W         = 27,
  parameter int REPEAT_DELAY  = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic            clk_100MHz,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_press
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [N_CH-1:0]  s1_q, s1_d, s2_q, s2_d;
  logic [N_CH-1:0]  level_q, level_d;
  logic [N_CH-1:0]  rise_q, rise_d, fall_q, fall_d, press_q, press_d;
  logic [N_CH-1:0]  tick_s;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [RPT_W-1:0] rpt_q [N_CH];
  logic [RPT_W-1:0] rpt_d [N_CH];
  rpt_state_e       state_q [N_CH];
  rpt_state_e       state_d [N_CH];

  always_comb begin
    s1_d    = btn_in;
    s2_d    = s1_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    tick_s  = '0;
    cnt_d   = cnt_q;
    rpt_d   = rpt_q;
    state_d = state_q;
    for (int i = 0; i < N_CH; i++) begin
      // Any cycle where the synchronised input agrees with the level restarts the count.
      if (s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == STABLE_LAST) begin
        level_d[i] = s2_q[i];
        rise_d[i]  = s2_q[i];
        fall_d[i]  = ~s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      case (state_q[i])
        ST_IDLE: begin
          rpt_d[i] = '0;
          if (rise_d[i] && repeat_en[i]) begin
            state_d[i] = ST_DELAY;
          end else begin
            state_d[i] = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!level_q[i] || fall_d[i] || !repeat_en[i]) begin
            state_d[i] = ST_IDLE;
            rpt_d[i]   = '0;
          end else if (rpt_q[i] == DELAY_LAST) begin
            tick_s[i]  = 1'b1;
            state_d[i] = ST_REPEAT;
            rpt_d[i]   = '0;
          end else begin
            rpt_d[i] = rpt_q[i] + RPT_W'(1);
          end
        end
        ST_REPEAT: begin
          // Abort outranks a tick due on the same edge.
          if (!level_q[i] || fall_d[i] || !repeat_en[i]) begin
            state_d[i] = ST_IDLE;
            rpt_d[i]   = '0;
          end else if (rpt_q[i] == PERIOD_LAST) begin
            tick_s[i] = 1'b1;
            rpt_d[i]  = '0;
          end else begin
            rpt_d[i] = rpt_q[i] + RPT_W'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          rpt_d[i]   = '0;
        end
      endcase
    end
    press_d = rise_d | tick_s;
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      press_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= '0;
        rpt_q[i]   <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      press_q <= press_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        rpt_q[i]   <= rpt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;
  assign btn_press = press_q;

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Scoreboard bench for btn_debounce_multi: expected strobe events are queued with their
// due cycle when stimulus is driven, and matched against the DUT on every falling edge.
module tb_btn_debounce_multi;

  localparam int N_CH = 2;
  localparam int RD   = 20;
  localparam int RP   = 5;
  localparam int LAT  = 10;

  logic            clk_100MHz = 1'b0;
  logic            rst;
  logic [N_CH-1:0] btn_in;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] btn_level, btn_rise, btn_fall, btn_press;

  typedef struct {
    int cyc;
    int ch;
    int kind; // 0 rise, 1 fall, 2 press
  } ev_t;

  ev_t             sb[$];
  int              cyc = 0;
  int              total = 0;
  int              bad = 0;
  logic            rst_smp = 1'b0;
  logic            mon_en = 1'b0;
  logic [N_CH-1:0] exp_level = '0;

  btn_debounce_multi #(
    .N_CH(N_CH), .CNT_W(4), .STABLE_CYCLES(8),
    .RPT_W(6), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .btn_in(btn_in),
    .repeat_en(repeat_en),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_press(btn_press)
  );

  initial forever #5 clk_100MHz = ~clk_100MHz;

  always @(posedge clk_100MHz) begin
    cyc     <= cyc + 1;
    rst_smp <= rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int ch, input int kind);
    ev_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.kind = kind;
    sb.push_back(e);
  endtask

  function automatic bit pop_ev(input int c, input int ch, input int kind);
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].cyc == c && sb[i].ch == ch && sb[i].kind == kind) begin
        sb.delete(i);
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Rise+press at r, repeat ticks while held (before fall f, not after stop), fall at f (f<0: none).
  task automatic push_hold(input int ch, input int r, input int f, input bit rpt, input int stop);
    push(r, ch, 0);
    push(r, ch, 2);
    if (rpt) begin
      for (int t = r + RD; (f < 0 || t < f) && t <= stop; t += RP) push(t, ch, 2);
    end
    if (f >= 0) push(f, ch, 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk_100MHz);
    #1;
  endtask

  initial begin
    logic [2:0] obs;
    bit         ex;
    string      kname;
    forever begin
      @(negedge clk_100MHz);
      if (mon_en) begin
        if (rst_smp) exp_level = '0;
        for (int ch = 0; ch < N_CH; ch++) begin
          obs = {btn_press[ch], btn_fall[ch], btn_rise[ch]};
          for (int k = 0; k < 3; k++) begin
            ex = pop_ev(cyc, ch, k);
            kname = (k == 0) ? "rise" : (k == 1) ? "fall" : "press";
            if (obs[k] || ex) chk($sformatf("ch%0d_%s", ch, kname), {31'd0, obs[k]}, {31'd0, ex});
            if (ex && k == 0) exp_level[ch] = 1'b1;
            if (ex && k == 1) exp_level[ch] = 1'b0;
          end
        end
        chk("level", {30'd0, btn_level}, {30'd0, exp_level});
      end
    end
  end

  initial begin
    int k;
    int r;
    rst       = 1'b1;
    btn_in    = 2'b11;
    repeat_en = 2'b00;
    wait_cyc(1);
    mon_en = 1'b1;
    wait_cyc(2);
    chk("rst_out", {24'd0, btn_level, btn_rise, btn_fall, btn_press}, 32'd0);

    // Buttons held through reset count as a fresh press after release.
    rst = 1'b0;
    k = cyc;
    push_hold(0, k + LAT, -1, 1'b0, 0);
    push_hold(1, k + LAT, -1, 1'b0, 0);
    wait_cyc(15);
    btn_in = 2'b00;
    k = cyc;
    push(k + LAT, 0, 1);
    push(k + LAT, 1, 1);
    wait_cyc(15);

    // 7-cycle glitch is rejected, 12-cycle pulse is accepted.
    btn_in[0] = 1'b1;
    wait_cyc(7);
    btn_in[0] = 1'b0;
    wait_cyc(15);
    btn_in[0] = 1'b1;
    k = cyc;
    push_hold(0, k + LAT, k + 12 + LAT, 1'b0, 0);
    wait_cyc(12);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    // Bounce on ch1, then settle high.
    for (int j = 0; j < 10; j++) begin
      btn_in[1] = (j % 2 == 0);
      wait_cyc(3);
    end
    btn_in[1] = 1'b1;
    k = cyc;
    push_hold(1, k + LAT, k + 30 + LAT, 1'b0, 0);
    wait_cyc(30);
    btn_in[1] = 1'b0;
    wait_cyc(15);

    // Auto-repeat on ch0, held 60 cycles past the rise.
    repeat_en = 2'b01;
    btn_in[0] = 1'b1;
    k = cyc;
    push_hold(0, k + LAT, k + 70 + LAT, 1'b1, 1 << 30);
    wait_cyc(70);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    // Same hold without repeat enabled.
    repeat_en = 2'b00;
    btn_in[0] = 1'b1;
    k = cyc;
    push_hold(0, k + LAT, k + 70 + LAT, 1'b0, 0);
    wait_cyc(70);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    // Drop repeat_en while repeating, then reset with the button held.
    repeat_en = 2'b01;
    btn_in[0] = 1'b1;
    r = cyc + LAT;
    push_hold(0, r, -1, 1'b1, r + 27);
    wait_cyc(37);
    repeat_en = 2'b00;
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    k = cyc;
    push_hold(0, k + LAT, k + 15 + LAT, 1'b0, 0);
    wait_cyc(15);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    // Both channels pressed together with independent repeat schedules.
    repeat_en = 2'b11;
    btn_in = 2'b11;
    r = cyc + LAT;
    push_hold(0, r, r + 50, 1'b1, 1 << 30);
    push_hold(1, r, r + 32, 1'b1, 1 << 30);
    wait_cyc(32);
    btn_in[1] = 1'b0;
    wait_cyc(18);
    btn_in[0] = 1'b0;
    wait_cyc(15);

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
